tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
Time-division 1->4 demultiplexer: the receive end of a 4-slot round-robin stream built by the team's mux4/mux2 datapath.
- Accepts one data beat per valid cycle.
- Aligns to a frame-sync marker on slot 0.
- Steers each beat into one of four registered output channels, with per-channel strobes, frame-done and sync-error flags.
- Sits between a serialized link and four parallel consumers.

Parameters:
WIDTH, 1, data width of din and of each channel output q0..q3

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  WIDTH  multiplexed data beat
din_valid  input  1  din carries a beat this cycle
sync  input  1  qualified by din_valid; marks the beat as slot 0 of a frame
q0  output  WIDTH  channel 0 data, registered, holds until next write
q1  output  WIDTH  channel 1 data, registered, holds until next write
q2  output  WIDTH  channel 2 data, registered, holds until next write
q3  output  WIDTH  channel 3 data, registered, holds until next write
q_valid  output  4  one-cycle strobe, bit k = qk written this cycle
slot  output  2  slot index expected for the next accepted beat
locked  output  1  1 = aligned to frame (LOCKED state)
frame_done  output  1  one-cycle pulse when slot 3 of a locked frame is written
sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values while rst_n=0: state HUNT; slot=0; q0..q3=0; q_valid=0; locked=0; frame_done=0; sync_err=0.
- Reset asserted mid-frame discards the partial frame. No output retains pre-reset data.
- Beat acceptance: a beat is accepted only on a rising clk edge with din_valid=1.
- Latency: 1 cycle. Data accepted at edge N appears on qk, with q_valid[k]=1, after edge N. At most one q_valid bit is high per cycle.
- Idle beats: with din_valid=0, slot, state and q0..q3 hold. q_valid, frame_done and sync_err return to 0 (pulses, never held).
- State HUNT (locked=0):
  - din_valid & sync: write q0, slot<=1, go LOCKED.
  - din_valid & !sync: beat dropped, no strobe, no error, slot stays 0.
- State LOCKED (locked=1), on an accepted beat:
  - slot==0 & sync: write q0, slot<=1.
  - slot==0 & !sync (missing sync): drop beat, sync_err pulse, go HUNT, slot<=0.
  - slot!=0 & !sync: write q[slot], slot<=slot+1 (2-bit wrap 3->0).
  - slot==3 & !sync: write q3 plus frame_done pulse in the same cycle as q_valid[3].
  - slot!=0 & sync (early sync): sync_err pulse, current partial frame abandoned. The beat is treated as a new slot 0: write q0, q_valid[0]=1, slot<=1, stay LOCKED. Channels already written in the abandoned frame keep their values. No frame_done.
- Non-written channels: never change except on reset.
- frame_done fires only after a complete, in-order 0..3 sequence begun by a sync beat.
- Back-to-back beats (din_valid held high) are accepted every cycle with no bubbles. Sustained throughput: 1 beat/cycle.
- sync with din_valid=0 is ignored.
- No X propagation: all outputs are driven from flops reset by rst_n.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, release, din_valid=0 for 5 cycles -> all outputs 0, locked=0, slot=0.
2. Normal frame, WIDTH=8: beats A1(sync),B2,C3,D4 on consecutive cycles -> q0=A1,q1=B2,q2=C3,q3=D4, q_valid one-hot 1,2,4,8 on successive cycles, frame_done=1 with q_valid=8, locked=1, slot back to 0.
3. Hunt: beats 11,22 (no sync), then 33(sync),44 -> first two dropped with no strobes, q0=33, q1=44, slot=2, sync_err never pulses.
4. Early sync: sync 01,02, then 03 with sync -> sync_err pulse, q0=03, q1 stays 02, slot=1, no frame_done.
5. Missing sync: complete frame 10,20,30,40, then 50 without sync -> sync_err pulse, locked=0, q0 stays 10, subsequent non-sync beats dropped.
6. Gapped stream plus reset mid-frame: frame beats separated by 3 idle cycles -> same q values as scenario 2. Then assert rst_n mid-frame asynchronously (between edges) -> outputs 0 immediately, HUNT on release.

Source files
------------

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//
// Purpose:
//   Receive end of a 4-slot round-robin TDM stream. Incoming beats are
//   aligned to a frame-sync marker that flags slot 0. Each accepted beat is
//   steered into one of four registered channel outputs. Each channel has a
//   one-cycle write strobe. The block also raises one-cycle frame-done and
//   sync-error pulses.
//
// Ports:
//   clk         in   1      system clock, rising-edge active
//   rst_n       in   1      asynchronous, active-low reset
//   din         in   WIDTH  multiplexed data beat
//   din_valid   in   1      din carries a beat this cycle
//   sync        in   1      with din_valid, marks the beat as slot 0
//   q0..q3      out  WIDTH  registered channel data, held until next write
//   q_valid     out  4      one-hot write strobe, bit k = qk written
//   slot        out  2      slot index expected for the next accepted beat
//   locked      out  1      1 while aligned to a frame
//   frame_done  out  1      pulse when slot 3 of a locked frame is written
//   sync_err    out  1      pulse on a framing violation
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [3:0]       q_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic [WIDTH-1:0] q2_q, q2_d;
    logic [WIDTH-1:0] q3_q, q3_d;
    logic [3:0]       q_valid_q, q_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;

    // Next-state logic. Channels, slot and state hold by default. The
    // strobes and the error and done flags default to 0 so that they are
    // only ever single-cycle pulses.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        q0_d         = q0_q;
        q1_d         = q1_q;
        q2_d         = q2_q;
        q3_d         = q3_q;
        q_valid_d    = 4'b0000;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Non-sync beats are dropped silently while searching.
                    if (sync) begin
                        q0_d      = din;
                        q_valid_d = 4'b0001;
                        slot_d    = 2'd1;
                        state_d   = LOCKED;
                    end
                end

                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (sync) begin
                            q0_d      = din;
                            q_valid_d = 4'b0001;
                            slot_d    = 2'd1;
                        end else begin
                            // A missing sync means alignment is lost.
                            // Drop the beat and search again.
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                            slot_d     = 2'd0;
                        end
                    end else if (sync) begin
                        // An early sync abandons the partial frame. It
                        // restarts at slot 0 without dropping lock.
                        sync_err_d = 1'b1;
                        q0_d       = din;
                        q_valid_d  = 4'b0001;
                        slot_d     = 2'd1;
                    end else begin
                        // Slot 0 can only be entered on a sync beat, so
                        // reaching slot 3 here means the frame was in order.
                        unique case (slot_q)
                            2'd1: q1_d = din;
                            2'd2: q2_d = din;
                            2'd3: begin
                                q3_d         = din;
                                frame_done_d = 1'b1;
                            end
                            default: ;
                        endcase
                        q_valid_d[slot_q] = 1'b1;
                        slot_d            = slot_q + 2'd1;
                    end
                end

                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    // State and output registers. Reset clears everything immediately, so
    // no data from a frame that was interrupted survives the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            q0_q         <= '0;
            q1_q         <= '0;
            q2_q         <= '0;
            q3_q         <= '0;
            q_valid_q    <= 4'b0000;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
            q2_q         <= q2_d;
            q3_q         <= q3_d;
            q_valid_q    <= q_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign q0         = q0_q;
    assign q1         = q1_q;
    assign q2         = q2_q;
    assign q3         = q3_q;
    assign q_valid    = q_valid_q;
    assign slot       = slot_q;
    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4
//
// Directed testbench for tdm_demux4 with WIDTH=8. Inputs change on the
// falling edge. Outputs are checked on the following falling edge, after
// the rising edge that accepted the beat.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] q0, q1, q2, q3;
    logic [3:0]       q_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             frame_done;
    logic             sync_err;

    int errors = 0;
    int checks = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .q_valid    (q_valid),
        .slot       (slot),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input from a falling edge and returns on the next
    // falling edge, after the rising edge in between has consumed it.
    task automatic applyStimulus(input logic v, input logic s,
                                 input logic [WIDTH-1:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(negedge clk);
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyIdle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        @(negedge clk);

        // Scenario 1: reset, then idle.
        applyIdle(2);
        checkOutput("rst_q0", q0, 0);
        checkOutput("rst_qvalid", q_valid, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_slot", slot, 0);
        rst_n = 1'b1;
        applyIdle(5);
        checkOutput("idle_q0", q0, 0);
        checkOutput("idle_q3", q3, 0);
        checkOutput("idle_qvalid", q_valid, 0);
        checkOutput("idle_locked", locked, 0);
        checkOutput("idle_slot", slot, 0);
        checkOutput("idle_flags", {frame_done, sync_err}, 0);

        // Scenario 2: normal frame, back-to-back beats.
        applyStimulus(1'b1, 1'b1, 8'hA1);
        checkOutput("s2_q0", q0, 32'hA1);
        checkOutput("s2_qv0", q_valid, 4'b0001);
        checkOutput("s2_locked", locked, 1);
        checkOutput("s2_slot1", slot, 1);
        applyStimulus(1'b1, 1'b0, 8'hB2);
        checkOutput("s2_q1", q1, 32'hB2);
        checkOutput("s2_qv1", q_valid, 4'b0010);
        checkOutput("s2_fd_early", frame_done, 0);
        applyStimulus(1'b1, 1'b0, 8'hC3);
        checkOutput("s2_q2", q2, 32'hC3);
        checkOutput("s2_qv2", q_valid, 4'b0100);
        applyStimulus(1'b1, 1'b0, 8'hD4);
        checkOutput("s2_q3", q3, 32'hD4);
        checkOutput("s2_qv3", q_valid, 4'b1000);
        checkOutput("s2_fd", frame_done, 1);
        checkOutput("s2_slot0", slot, 0);
        checkOutput("s2_locked_end", locked, 1);
        applyIdle(1);
        checkOutput("s2_idle_qv", q_valid, 0);
        checkOutput("s2_idle_fd", frame_done, 0);
        checkOutput("s2_hold_q0", q0, 32'hA1);

        // Scenario 3: hunt drops non-sync beats.
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'h11);
        checkOutput("s3_drop_qv", q_valid, 0);
        checkOutput("s3_drop_err", sync_err, 0);
        applyStimulus(1'b1, 1'b0, 8'h22);
        checkOutput("s3_drop_q0", q0, 0);
        checkOutput("s3_drop_slot", slot, 0);
        checkOutput("s3_drop_locked", locked, 0);
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkOutput("s3_q0", q0, 32'h33);
        checkOutput("s3_lock", locked, 1);
        applyStimulus(1'b1, 1'b0, 8'h44);
        checkOutput("s3_q1", q1, 32'h44);
        checkOutput("s3_slot", slot, 2);
        checkOutput("s3_err", sync_err, 0);

        // Scenario 4: early sync restarts the frame.
        applyReset();
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02);
        applyStimulus(1'b1, 1'b1, 8'h03);
        checkOutput("s4_err", sync_err, 1);
        checkOutput("s4_q0", q0, 32'h03);
        checkOutput("s4_qv", q_valid, 4'b0001);
        checkOutput("s4_q1_hold", q1, 32'h02);
        checkOutput("s4_slot", slot, 1);
        checkOutput("s4_fd", frame_done, 0);
        checkOutput("s4_locked", locked, 1);
        applyIdle(1);
        checkOutput("s4_err_pulse", sync_err, 0);

        // Scenario 5: missing sync drops lock.
        applyReset();
        applyStimulus(1'b1, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'h20);
        applyStimulus(1'b1, 1'b0, 8'h30);
        applyStimulus(1'b1, 1'b0, 8'h40);
        checkOutput("s5_fd", frame_done, 1);
        applyStimulus(1'b1, 1'b0, 8'h50);
        checkOutput("s5_err", sync_err, 1);
        checkOutput("s5_unlock", locked, 0);
        checkOutput("s5_qv", q_valid, 0);
        checkOutput("s5_q0_hold", q0, 32'h10);
        checkOutput("s5_slot", slot, 0);
        applyStimulus(1'b1, 1'b0, 8'h60);
        checkOutput("s5_drop_qv", q_valid, 0);
        checkOutput("s5_drop_err", sync_err, 0);
        checkOutput("s5_q1_hold", q1, 32'h20);

        // Scenario 6: gapped frame, then asynchronous reset mid-frame.
        applyReset();
        applyStimulus(1'b1, 1'b1, 8'hA1);
        applyIdle(3);
        checkOutput("s6_gap_slot", slot, 1);
        checkOutput("s6_gap_qv", q_valid, 0);
        applyStimulus(1'b1, 1'b0, 8'hB2);
        applyIdle(3);
        applyStimulus(1'b1, 1'b0, 8'hC3);
        applyIdle(3);
        applyStimulus(1'b1, 1'b0, 8'hD4);
        checkOutput("s6_fd", frame_done, 1);
        checkOutput("s6_q", {q0, q1, q2, q3}, 32'hA1B2C3D4);
        applyStimulus(1'b1, 1'b1, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkOutput("s6_pre_q1", q1, 32'h66);
        din_valid = 1'b0;
        sync      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s6_async_q", {q0, q1, q2, q3}, 0);
        checkOutput("s6_async_locked", locked, 0);
        checkOutput("s6_async_slot", slot, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h77);
        checkOutput("s6_hunt_qv", q_valid, 0);
        checkOutput("s6_hunt_q0", q0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
